// File: rtl/fpu_addsub.sv
// Multi-cycle IEEE-754 style floating-point adder/subtractor, sequenced by an FSM.
// Define FPU_ADDSUB_FTZ_EN to treat subnormal inputs as zero and flush subnormal results to zero.
module fpu_addsub #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din1,
    input  logic [W-1:0] din2,
    input  logic         sub,
    input  logic [2:0]   rm,
    input  logic         dval,
    output logic [W-1:0] result,
    output logic [4:0]   flags,
    output logic         rdy,
    output logic         busy
);
    // state   | meaning
    // IDLE    | waiting for dval
    // UNPACK  | split operands into sign/exponent/significand, classify
    // SPECIAL | NaN/inf/zero short-cut straight to OUT
    // ALIGN   | order by magnitude, right-shift smaller operand with sticky
    // ADD     | add or subtract aligned significands
    // NORM    | leading-zero normalise, clamped at minimum exponent
    // ROUND   | round per rm, overflow/underflow handling
    // OUT     | drive result/flags, pulse rdy
    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_SPECIAL, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_OUT
    } state_t;

    localparam int SW = MAN_W + 4;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W:0]   sig;
        logic             nan;
        logic             snan;
        logic             inf;
        logic             zero;
    } op_t;

    state_t         state;
    logic [W-1:0]   a_r, b_r;
    logic           sub_r;
    logic [2:0]     rm_r;
    op_t            op_a_r, op_b_r;
    logic [SW-1:0]  big_r, small_r, norm_r;
    logic [SW:0]    sum_r;
    logic [EXP_W:0] exp_r;
    logic           sign_r, esub_r, zero_r;
    logic [W-1:0]   res_pre;
    logic [4:0]     flg_pre;

    function automatic op_t unpack(input logic [W-1:0] x, input logic flip);
        op_t o;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e      = x[W-2:MAN_W];
        m      = x[MAN_W-1:0];
        o.s    = x[W-1] ^ flip;
        o.e    = (e == '0) ? EXP_W'(1) : e;
        o.sig  = {e != '0, m};
        o.nan  = (e == EXP_MAX) && (m != '0);
        o.snan = o.nan && !m[MAN_W-1];
        o.inf  = (e == EXP_MAX) && (m == '0);
`ifdef FPU_ADDSUB_FTZ_EN
        o.zero = (e == '0);
`else
        o.zero = (e == '0) && (m == '0);
`endif
        return o;
    endfunction

    function automatic int lzc(input logic [SW-1:0] v);
        int n;
        n = SW;
        for (int i = 0; i < SW; i++)
            if (v[i]) n = SW - 1 - i;
        return n;
    endfunction

    // Special-operand short-cut
    logic [W-1:0] sp_res;
    logic [4:0]   sp_flg;
    logic         sp_take;
    always_comb begin
        sp_res  = '0;
        sp_flg  = '0;
        sp_take = op_a_r.nan | op_b_r.nan | op_a_r.inf | op_b_r.inf | op_a_r.zero | op_b_r.zero;
        if (op_a_r.nan || op_b_r.nan) begin
            sp_res    = QNAN;
            sp_flg[4] = op_a_r.snan | op_b_r.snan;
        end else if (op_a_r.inf && op_b_r.inf && (op_a_r.s != op_b_r.s)) begin
            sp_res    = QNAN;
            sp_flg[4] = 1'b1;
        end else if (op_a_r.inf) begin
            sp_res = {op_a_r.s, EXP_MAX, {MAN_W{1'b0}}};
        end else if (op_b_r.inf) begin
            sp_res = {op_b_r.s, EXP_MAX, {MAN_W{1'b0}}};
        end else if (op_a_r.zero && op_b_r.zero) begin
            sp_res = {(op_a_r.s == op_b_r.s) ? op_a_r.s : (rm_r == 3'b010), {(W-1){1'b0}}};
        end else if (op_a_r.zero) begin
            sp_res = {op_b_r.s, b_r[W-2:0]};
        end else if (op_b_r.zero) begin
            sp_res = {op_a_r.s, a_r[W-2:0]};
        end
    end

    // Alignment
    op_t             big_op, sm_op;
    logic [EXP_W-1:0] diff;
    logic [2*SW-1:0] sh_full;
    logic [SW-1:0]   aligned;
    always_comb begin
        if (a_r[W-2:0] >= b_r[W-2:0]) begin
            big_op = op_a_r;
            sm_op  = op_b_r;
        end else begin
            big_op = op_b_r;
            sm_op  = op_a_r;
        end
        diff    = big_op.e - sm_op.e;
        sh_full = {sm_op.sig, 3'b000, {SW{1'b0}}} >> diff;
        if (int'(diff) >= MAN_W + 3)
            aligned = SW'(|sm_op.sig);
        else
            aligned = sh_full[2*SW-1:SW] | SW'(|sh_full[SW-1:0]);
    end

    // Normalisation
    int             lz, lim, sh;
    logic [SW-1:0]  norm_nx;
    logic [EXP_W:0] exp_nx;
    always_comb begin
        lz      = lzc(sum_r[SW-1:0]);
        lim     = int'(exp_r) - 1;
        sh      = (lz < lim) ? lz : lim;
        norm_nx = sum_r[SW-1:0] << sh;
        exp_nx  = exp_r - (EXP_W+1)'(sh);
        if (sum_r[SW]) begin
            norm_nx = {sum_r[SW:2], sum_r[1] | sum_r[0]};
            exp_nx  = exp_r + (EXP_W+1)'(1);
        end
    end

    // Rounding and result packing
    logic [MAN_W:0]   m, mf;
    logic [MAN_W+1:0] mr;
    logic [EXP_W:0]   ef;
    logic [EXP_W-1:0] enc;
    logic             g, r, st, nx, inc, tiny, to_inf;
    logic [W-1:0]     rd_res;
    logic [4:0]       rd_flg;
    always_comb begin
        m  = norm_r[SW-1:3];
        g  = norm_r[2];
        r  = norm_r[1];
        st = norm_r[0];
        nx = g | r | st;
        case (rm_r)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign_r & nx;
            3'b011:  inc = ~sign_r & nx;
            3'b100:  inc = g;
            default: inc = g & (r | st | m[0]);
        endcase
        mr = {1'b0, m} + (MAN_W+2)'(inc);
        if (mr[MAN_W+1]) begin
            mf = mr[MAN_W+1:1];
            ef = exp_r + (EXP_W+1)'(1);
        end else begin
            mf = mr[MAN_W:0];
            ef = exp_r;
        end
        tiny   = ~mf[MAN_W];
        enc    = tiny ? '0 : ef[EXP_W-1:0];
        to_inf = (rm_r == 3'b000) || (rm_r == 3'b100) || (rm_r > 3'b100) ||
                 ((rm_r == 3'b010) && sign_r) || ((rm_r == 3'b011) && !sign_r);
        rd_res = {sign_r, enc, mf[MAN_W-1:0]};
        rd_flg = {3'b000, tiny & nx, nx};
        if (zero_r) begin
            rd_res = {rm_r == 3'b010, {(W-1){1'b0}}};
            rd_flg = '0;
        end else if (ef >= {1'b0, EXP_MAX}) begin
            rd_res = to_inf ? {sign_r, EXP_MAX, {MAN_W{1'b0}}}
                            : {sign_r, EXP_MAX - EXP_W'(1), {MAN_W{1'b1}}};
            rd_flg = 5'b00101;
        end
`ifdef FPU_ADDSUB_FTZ_EN
        else if (tiny) begin
            rd_res = {sign_r, {(W-1){1'b0}}};
            rd_flg = 5'b00011;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            sub_r   <= 1'b0;
            rm_r    <= '0;
            op_a_r  <= '0;
            op_b_r  <= '0;
            big_r   <= '0;
            small_r <= '0;
            sum_r   <= '0;
            norm_r  <= '0;
            exp_r   <= '0;
            sign_r  <= 1'b0;
            esub_r  <= 1'b0;
            zero_r  <= 1'b0;
            res_pre <= '0;
            flg_pre <= '0;
            result  <= '0;
            flags   <= '0;
            rdy     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            rdy <= 1'b0;
            case (state)
                S_IDLE: if (dval) begin
                    a_r   <= din1;
                    b_r   <= din2;
                    sub_r <= sub;
                    rm_r  <= rm;
                    busy  <= 1'b1;
                    state <= S_UNPACK;
                end
                S_UNPACK: begin
                    op_a_r <= unpack(a_r, 1'b0);
                    op_b_r <= unpack(b_r, sub_r);
                    state  <= S_SPECIAL;
                end
                S_SPECIAL: begin
                    if (sp_take) begin
                        res_pre <= sp_res;
                        flg_pre <= sp_flg;
                        state   <= S_OUT;
                    end else begin
                        state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    big_r   <= {big_op.sig, 3'b000};
                    small_r <= aligned;
                    exp_r   <= {1'b0, big_op.e};
                    sign_r  <= big_op.s;
                    esub_r  <= op_a_r.s ^ op_b_r.s;
                    state   <= S_ADD;
                end
                S_ADD: begin
                    sum_r <= esub_r ? ({1'b0, big_r} - {1'b0, small_r})
                                    : ({1'b0, big_r} + {1'b0, small_r});
                    state <= S_NORM;
                end
                S_NORM: begin
                    norm_r <= norm_nx;
                    exp_r  <= exp_nx;
                    zero_r <= (sum_r == '0);
                    state  <= S_ROUND;
                end
                S_ROUND: begin
                    res_pre <= rd_res;
                    flg_pre <= rd_flg;
                    state   <= S_OUT;
                end
                S_OUT: begin
                    result <= res_pre;
                    flags  <= flg_pre;
                    rdy    <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_addsub.sv
// Scoreboard bench for fpu_addsub (binary32): directed vectors, queued expectations, rdy-driven monitor.
module tb_fpu_addsub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din1 = '0, din2 = '0;
    logic        sub = 1'b0;
    logic [2:0]  rm = '0;
    logic        dval = 1'b0;
    logic [31:0] result;
    logic [4:0]  flags;
    logic        rdy, busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        int          acc;
    } exp_t;
    exp_t q[$];

    fpu_addsub #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .din1(din1), .din2(din2), .sub(sub), .rm(rm),
        .dval(dval), .result(result), .flags(flags), .rdy(rdy), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every rdy pulse consumes one expectation.
    always @(negedge clk) begin
        if (rst_n && rdy) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rdy: got result %h with no pending request", result);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", result, e.res);
                chk("flags", 32'(flags), 32'(e.fl));
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [2:0] m, input logic [31:0] er, input logic [4:0] ef,
                         input int lat);
        int n;
        @(negedge clk);
        din1 = a; din2 = b; sub = s; rm = m; dval = 1'b1;
        q.push_back('{er, ef, lat, cyc + 1});
        @(posedge clk);
        #1 dval = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            if (rdy) break;
            n++;
        end
        if (n >= 30) begin
            tests++;
            fails++;
            $display("FAIL rdy_timeout: got no rdy within 30 cycles, expected rdy");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rdy", 32'(rdy), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;

        issue(32'h3F800000, 32'h40000000, 1'b0, 3'b000, 32'h40400000, 5'b00000, 7);
        issue(32'h3F800000, 32'h3F800000, 1'b1, 3'b000, 32'h00000000, 5'b00000, 7);
        issue(32'h3F800000, 32'h3F800000, 1'b1, 3'b010, 32'h80000000, 5'b00000, 7);
        issue(32'h7F800000, 32'hFF800000, 1'b0, 3'b000, 32'h7FC00000, 5'b10000, 3);
        issue(32'h7F800001, 32'h3F800000, 1'b0, 3'b000, 32'h7FC00000, 5'b10000, 3);
        issue(32'h7FC00000, 32'h3F800000, 1'b0, 3'b000, 32'h7FC00000, 5'b00000, 3);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b000, 32'h7F800000, 5'b00101, 7);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b001, 32'h7F7FFFFF, 5'b00101, 7);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b010, 32'h7F7FFFFF, 5'b00101, 7);
        issue(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'b010, 32'hFF800000, 5'b00101, 7);
        issue(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'b011, 32'hFF7FFFFF, 5'b00101, 7);
        issue(32'h3F800000, 32'h33800000, 1'b0, 3'b000, 32'h3F800000, 5'b00001, 7);
        issue(32'h3F800000, 32'h33800000, 1'b0, 3'b011, 32'h3F800001, 5'b00001, 7);
        issue(32'h3F800000, 32'h33800000, 1'b0, 3'b100, 32'h3F800001, 5'b00001, 7);
        issue(32'h3F800000, 32'h33800000, 1'b0, 3'b001, 32'h3F800000, 5'b00001, 7);
        issue(32'h40400000, 32'h3F800000, 1'b1, 3'b000, 32'h40000000, 5'b00000, 7);
        issue(32'h00000000, 32'h80000000, 1'b0, 3'b000, 32'h00000000, 5'b00000, 3);
        issue(32'h00000000, 32'h80000000, 1'b0, 3'b010, 32'h80000000, 5'b00000, 3);
        issue(32'h80000000, 32'h80000000, 1'b0, 3'b000, 32'h80000000, 5'b00000, 3);
`ifdef FPU_ADDSUB_FTZ_EN
        issue(32'h00000001, 32'h00000001, 1'b0, 3'b000, 32'h00000000, 5'b00000, 3);
        issue(32'h00800000, 32'h00000001, 1'b1, 3'b000, 32'h00800000, 5'b00000, 3);
`else
        issue(32'h00000001, 32'h00000001, 1'b0, 3'b000, 32'h00000002, 5'b00000, 7);
        issue(32'h00800000, 32'h00000001, 1'b1, 3'b000, 32'h007FFFFF, 5'b00000, 7);
`endif
        issue(32'h3F800000, 32'h40000000, 1'b0, 3'b000, 32'h40400000, 5'b00000, 7);

        // Reset while the operation sits in ALIGN: discarded, outputs cleared at once.
        @(negedge clk);
        din1 = 32'h3F800000; din2 = 32'h3F800000; sub = 1'b0; rm = 3'b000; dval = 1'b1;
        @(posedge clk);
        #1 dval = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midop_reset_rdy", 32'(rdy), 32'd0);
        chk("midop_reset_busy", 32'(busy), 32'd0);
        chk("midop_reset_result", result, 32'd0);
        chk("midop_reset_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        issue(32'h3F800000, 32'h40000000, 1'b0, 3'b000, 32'h40400000, 5'b00000, 7);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fpu_addsub.md
FPU_ADDSUB -- requirements
Module: fpu_addsub

Interface
REQ-001 SHALL provide parameter EXP_W, default 8, exponent field width (legal range 5..11).
REQ-002 SHALL provide parameter MAN_W, default 23, stored mantissa field width (legal range 10..52).
REQ-003 SHALL define W = 1+EXP_W+MAN_W; port clk  input  1  single clock, rising edge.
REQ-004 SHALL provide rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL provide din1  input  W  operand A, IEEE-754 style encoding.
REQ-006 SHALL provide din2  input  W  operand B.
REQ-007 SHALL provide sub  input  1  1 = compute A-B, 0 = compute A+B.
REQ-008 SHALL provide rm  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-009 SHALL provide dval  input  1  request strobe, sampled only when idle.
REQ-010 SHALL provide result  output  W  sum/difference, held until next rdy.
REQ-011 SHALL provide flags  output  5  {NV, DZ, OF, UF, NX}; DZ is always 0.
REQ-012 SHALL provide rdy  output  1  one-cycle pulse, result/flags valid.
REQ-013 SHALL provide busy  output  1  high from request acceptance until the cycle rdy is high.

Function
REQ-014 SHALL capture din1, din2, sub and rm on the clock edge where state is IDLE and dval=1, and ignore dval at all other times.
REQ-015 SHALL sequence states IDLE -> UNPACK -> SPECIAL -> ALIGN -> ADD -> NORM -> ROUND -> OUT -> IDLE, one cycle each, so rdy rises 7 cycles after the accepting edge.
REQ-016 SHALL branch SPECIAL -> OUT for NaN, infinity or zero operands, giving rdy 3 cycles after acceptance.
REQ-017 SHALL take effective B sign as B.sign XOR sub, and apply all following rules to it.
REQ-018 SHALL return canonical NaN, meaning sign 0, exponent all ones, mantissa MSB 1 and rest 0, for any NaN input.
REQ-019 SHALL set NV for signalling NaN input or for +inf combined with -inf.
REQ-020 SHALL align in a single-cycle barrel shift, with shifted-out bits ORed into a sticky bit; shifts >= MAN_W+3 reduce the operand to sticky only.
REQ-021 SHALL normalise in a single cycle using leading-zero count, clamped at the minimum exponent to produce subnormals.
REQ-022 SHALL round per rm using guard/round/sticky; mantissa carry-out SHALL increment the exponent.
REQ-023 SHALL produce on overflow +/-inf under RNE/RMM, under RTZ max-finite, under RDN/RUP the direction-dependent value; OF and NX are set in all cases.
REQ-024 SHALL set UF when the rounded result is subnormal or zero from nonzero and inexact; NX whenever any discarded bit is nonzero.
REQ-025 SHALL give an exact zero sum of opposite-signed operands sign +0, except -0 under RDN; x+x for zero x keeps the sign of x.
REQ-026 SHALL drive result and flags only in OUT, and hold them stable until the next OUT.

Reset
REQ-027 SHALL on rst_n=0 immediately force state IDLE, rdy=0, busy=0, result=0, flags=0, whatever the state.
REQ-028 SHALL discard an operation interrupted by reset; the first request after rst_n rises SHALL be accepted normally.

Configuration
REQ-029 SHALL when macro FPU_ADDSUB_FTZ_EN is defined treat subnormal inputs as same-signed zero and flush subnormal results to same-signed zero, setting UF and NX.
REQ-030 SHALL without FPU_ADDSUB_FTZ_EN handle subnormal inputs and results with full gradual underflow.

Verification (EXP_W=8, MAN_W=23)
REQ-031 SHALL cover 0x3F800000 + 0x40000000, RNE -> 0x40400000, flags 0, rdy 7 cycles after dval.
REQ-032 SHALL cover 0x3F800000 - 0x3F800000 (sub=1): RNE -> 0x00000000; RDN -> 0x80000000.
REQ-033 SHALL cover 0x7F800000 + 0xFF800000 -> 0x7FC00000, NV=1, rdy 3 cycles after dval.
REQ-034 SHALL cover 0x7F7FFFFF + 0x7F7FFFFF: RNE -> 0x7F800000 flags OF|NX; RTZ -> 0x7F7FFFFF flags OF|NX.
REQ-035 SHALL cover 0x3F800000 + 0x33800000: RNE -> 0x3F800000 NX; RUP -> 0x3F800001 NX.
REQ-036 SHALL cover 0x00000001 + 0x00000001 -> 0x00000002 flags 0 without FTZ; reset asserted in ALIGN -> no rdy, all outputs 0.
